axi_mm_burst_slave: RTL and testbench
=====================================

// Module: axi_mm_burst_slave
// PURPOSE
// - AXI4 memory-mapped burst slave with an internal word memory, INCR bursts only.
// - Accepts write bursts (AW/W/B) and serves read bursts (AR/R) on independent FSMs.
// - Sits behind an AXI master as a target/scratch memory for bursts up to 2**LSIZE beats.
// PARAMETERS
// - ASIZE  32  address width; the address is a word address (not a byte address)
// - DSIZE  32  data width
// - LSIZE  8   burst-length field width; beats = len+1
// - ID     0   value driven on bid/rid
// - IDSIZE 4   width of bid/rid
// - DEPTH  256 memory words; word index = addr mod DEPTH
// PORTS
// - sys_clk  in  1       clock, rising edge
// - sys_rst  in  1       asynchronous reset, active-high
// - awaddr   in  ASIZE   write start address
// - awlen    in  LSIZE   write beats-1
// - awvalid  in  1       / awready out 1
// - wdata    in  DSIZE   write data
// - wlast    in  1       last write beat
// - wvalid   in  1       / wready out 1
// - bid      out IDSIZE  = ID
// - bresp    out 2       00 OKAY, 10 SLVERR
// - bvalid   out 1       / bready in 1
// - araddr   in  ASIZE   read start address
// - arlen    in  LSIZE   read beats-1
// - arvalid  in  1       / arready out 1
// - rid      out IDSIZE  = ID
// - rdata    out DSIZE   read data
// - rresp    out 2       always 00
// - rlast    out 1       last read beat
// - rvalid   out 1       / rready in 1
// BEHAVIOUR
// - Reset: all valid/ready outputs 0, rdata/bresp/rlast 0, both FSMs to IDLE; memory contents not reset.
// - Handshake: a transfer occurs on a rising edge where valid&&ready; valid, once high, holds with stable payload until accepted.
// - Write FSM:
//   - W_IDLE (awready=1): AW handshake latches addr/len, beat count=0 -> W_DATA.
//   - W_DATA (wready=1): each W handshake writes mem[(addr+beat) mod DEPTH], beat++.
//     On beat==len -> W_RESP, awready first re-asserts one cycle after the B handshake.
//   - W_RESP (bvalid=1): hold until bready, then -> W_IDLE.
// - Read FSM:
//   - R_IDLE (arready=1): AR handshake latches addr/len -> R_DATA.
//   - R_DATA: rvalid rises the cycle after AR acceptance with mem[addr].
//     Each R handshake advances to (addr+beat) mod DEPTH; rlast=1 on beat len; after last handshake -> R_IDLE.
//   - rdata is registered; rdata/rlast stable while rvalid && !rready.
// - Address increments wrap modulo DEPTH; awlen=0 and arlen=0 are single-beat bursts.
// - Write and read run concurrently. A same-word read and write in the same cycle return the old data.
// - Reset asserted mid-burst aborts the burst immediately; partially written words keep their values.
// CONFIGURATION
// - AXI_SLV_ERR_CHECK_EN defined:
//   - wlast is checked on every beat; wlast on beat<len, or missing on beat==len, sets a sticky error for the burst.
//   - Burst still ends at beat==len; bresp=10 if the error is set, else 00.
// - Not defined: wlast ignored, the burst ends on beat count, bresp always 00.
// TESTING
// - Write awaddr=100 awlen=8 data {0,1,2,3,4,5,100,101,901} -> one bvalid, bresp=00, bid=0.
//   Read araddr=100 arlen=8 -> same 9 words, rlast only on beat 9.
// - Three back-to-back identical write bursts to 100 -> exactly three B handshakes, memory unchanged vs single burst.
// - awaddr=DEPTH-2 awlen=3 data {A,B,C,D} -> mem[254]=A, mem[255]=B, mem[0]=C, mem[1]=D; read-back wraps identically.
// - wvalid gaps of 2 cycles and bready low 5 cycles -> no beat lost, bvalid held high until bready, awready 0 meanwhile.
//   rready toggling -> rdata stable while stalled.
// - sys_rst pulsed at beat 4 of a 9-beat write -> all valids 0 immediately; awready=1 after release; new burst completes.
// - With AXI_SLV_ERR_CHECK_EN: wlast on beat 3 of awlen=8 -> bresp=10; correct wlast -> bresp=00.

Source files
------------

// File: rtl/axi_mm_burst_slave.sv
// AXI4 memory-mapped INCR burst slave over an internal word memory; independent write and read FSMs.
// Define AXI_SLV_ERR_CHECK_EN to check wlast placement and report SLVERR on bresp.
module axi_mm_burst_slave #(
    parameter int ASIZE  = 32,
    parameter int DSIZE  = 32,
    parameter int LSIZE  = 8,
    parameter int ID     = 0,
    parameter int IDSIZE = 4,
    parameter int DEPTH  = 256
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic [ASIZE-1:0]  awaddr,
    input  logic [LSIZE-1:0]  awlen,
    input  logic              awvalid,
    output logic              awready,
    input  logic [DSIZE-1:0]  wdata,
    input  logic              wlast,
    input  logic              wvalid,
    output logic              wready,
    output logic [IDSIZE-1:0] bid,
    output logic [1:0]        bresp,
    output logic              bvalid,
    input  logic              bready,
    input  logic [ASIZE-1:0]  araddr,
    input  logic [LSIZE-1:0]  arlen,
    input  logic              arvalid,
    output logic              arready,
    output logic [IDSIZE-1:0] rid,
    output logic [DSIZE-1:0]  rdata,
    output logic [1:0]        rresp,
    output logic              rlast,
    output logic              rvalid,
    input  logic              rready
);

    localparam int               AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ASIZE-1:0] DEPTH_A  = ASIZE'(DEPTH);
    localparam logic [AW-1:0]    LAST_IDX = AW'(DEPTH - 1);
    localparam logic [AW-1:0]    PTR_ONE  = AW'(1);
    localparam logic [LSIZE-1:0] BEAT_ONE = LSIZE'(1);

    localparam logic [1:0] W_IDLE = 2'd0;
    localparam logic [1:0] W_DATA = 2'd1;
    localparam logic [1:0] W_RESP = 2'd2;
    localparam logic       R_IDLE = 1'b0;
    localparam logic       R_DATA = 1'b1;

    logic [DSIZE-1:0] mem [0:DEPTH-1];

    logic [1:0]       w_state;
    logic [AW-1:0]    w_ptr;
    logic [LSIZE-1:0] w_len;
    logic [LSIZE-1:0] w_beat;
    logic             w_err;
    logic             r_state;
    logic [AW-1:0]    r_ptr;
    logic [LSIZE-1:0] r_len;
    logic [LSIZE-1:0] r_beat;

    logic [AW-1:0] aw_idx;
    logic [AW-1:0] ar_idx;
    logic [AW-1:0] w_ptr_next;
    logic [AW-1:0] r_ptr_next;
    logic          w_final;
    logic          w_fire;
    logic          beat_err;

    // Start addresses are word addresses reduced modulo DEPTH; pointers then wrap at DEPTH-1.
    assign aw_idx     = AW'(awaddr % DEPTH_A);
    assign ar_idx     = AW'(araddr % DEPTH_A);
    assign w_ptr_next = (w_ptr == LAST_IDX) ? '0 : w_ptr + PTR_ONE;
    assign r_ptr_next = (r_ptr == LAST_IDX) ? '0 : r_ptr + PTR_ONE;
    assign w_final    = (w_beat == w_len);
    assign w_fire     = (w_state == W_DATA) && wvalid && wready;

    assign bid   = IDSIZE'(ID);
    assign rid   = IDSIZE'(ID);
    assign rresp = 2'b00;

`ifdef AXI_SLV_ERR_CHECK_EN
    assign beat_err = (wlast != w_final);
`else
    logic unused_wlast;
    assign unused_wlast = wlast;
    assign beat_err     = 1'b0;
`endif

    always_ff @(posedge sys_clk) begin
        if (w_fire) begin
            mem[w_ptr] <= wdata;
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            w_state <= W_IDLE;
            awready <= 1'b0;
            wready  <= 1'b0;
            bvalid  <= 1'b0;
            bresp   <= 2'b00;
            w_ptr   <= '0;
            w_len   <= '0;
            w_beat  <= '0;
            w_err   <= 1'b0;
        end else begin
            case (w_state)
                W_IDLE: begin
                    if (awvalid && awready) begin
                        w_ptr   <= aw_idx;
                        w_len   <= awlen;
                        w_beat  <= '0;
                        w_err   <= 1'b0;
                        awready <= 1'b0;
                        wready  <= 1'b1;
                        w_state <= W_DATA;
                    end else begin
                        awready <= 1'b1;
                    end
                end
                W_DATA: begin
                    // The burst always ends on the beat count; wlast only feeds the error flag.
                    if (w_fire) begin
                        if (w_final) begin
                            wready  <= 1'b0;
                            bvalid  <= 1'b1;
                            bresp   <= (w_err || beat_err) ? 2'b10 : 2'b00;
                            w_state <= W_RESP;
                        end else begin
                            w_beat <= w_beat + BEAT_ONE;
                            w_ptr  <= w_ptr_next;
                            w_err  <= w_err || beat_err;
                        end
                    end
                end
                W_RESP: begin
                    if (bready) begin
                        bvalid  <= 1'b0;
                        bresp   <= 2'b00;
                        awready <= 1'b1;
                        w_state <= W_IDLE;
                    end
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    // rdata is loaded on acceptance of AR and on each R handshake, so it holds while stalled.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_state <= R_IDLE;
            arready <= 1'b0;
            rvalid  <= 1'b0;
            rlast   <= 1'b0;
            rdata   <= '0;
            r_ptr   <= '0;
            r_len   <= '0;
            r_beat  <= '0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (arvalid && arready) begin
                        r_ptr   <= ar_idx;
                        r_len   <= arlen;
                        r_beat  <= '0;
                        rdata   <= mem[ar_idx];
                        rlast   <= (arlen == '0);
                        rvalid  <= 1'b1;
                        arready <= 1'b0;
                        r_state <= R_DATA;
                    end else begin
                        arready <= 1'b1;
                    end
                end
                R_DATA: begin
                    if (rready) begin
                        if (r_beat == r_len) begin
                            rvalid  <= 1'b0;
                            rlast   <= 1'b0;
                            arready <= 1'b1;
                            r_state <= R_IDLE;
                        end else begin
                            r_beat <= r_beat + BEAT_ONE;
                            r_ptr  <= r_ptr_next;
                            rdata  <= mem[r_ptr_next];
                            rlast  <= ((r_beat + BEAT_ONE) == r_len);
                        end
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_mm_burst_slave.sv
// Directed self-checking bench for axi_mm_burst_slave: bursts, wrap, stalls, mid-burst reset, wlast checking.
module tb_axi_mm_burst_slave;

    logic        sys_clk = 1'b0;
    logic        sys_rst;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic        wlast;
    logic        wvalid;
    logic        wready;
    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic        arvalid;
    logic        arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;

    int compare_count  = 0;
    int mismatch_count = 0;
    int b_count        = 0;

    logic [31:0] wbuf [0:15];
    logic [31:0] rbuf [0:15];
    logic        rlast_buf [0:15];
    logic [1:0]  last_bresp;
    logic [3:0]  last_bid;
    logic [3:0]  last_rid;

    axi_mm_burst_slave dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst),
        .awaddr(awaddr), .awlen(awlen), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arlen(arlen), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
    );

    always #5 sys_clk = ~sys_clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, got running required finished");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        compare_count++;
        if (actual !== expected) begin
            mismatch_count++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    // Write burst from wbuf; bad_last<0 means correct wlast, abort_at>=0 stops before that beat.
    task automatic applyStimulus(input logic [31:0] addr, input int len, input int gap,
                                 input int bready_delay, input int bad_last, input int abort_at);
        int cnt;
        awaddr  = addr;
        awlen   = 8'(len);
        awvalid = 1'b1;
        cnt = 0;
        while (!awready && cnt < 200) begin tick(); cnt++; end
        if (cnt >= 200) checkOutput("aw_timeout", 1, 0);
        tick();
        awvalid = 1'b0;
        for (int i = 0; i <= len; i++) begin
            if (i == abort_at) return;
            repeat (gap) tick();
            wdata  = wbuf[i];
            wlast  = (bad_last >= 0) ? (i == bad_last) : (i == len);
            wvalid = 1'b1;
            cnt = 0;
            while (!wready && cnt < 200) begin tick(); cnt++; end
            if (cnt >= 200) checkOutput("w_timeout", 1, 0);
            tick();
            wvalid = 1'b0;
            wlast  = 1'b0;
        end
        if (bready_delay > 0) begin
            repeat (bready_delay) tick();
            checkOutput("bvalid_held", bvalid, 1);
            checkOutput("awready_busy", awready, 0);
        end
        bready = 1'b1;
        cnt = 0;
        while (!bvalid && cnt < 200) begin tick(); cnt++; end
        if (cnt >= 200) checkOutput("b_timeout", 1, 0);
        last_bresp = bresp;
        last_bid   = bid;
        tick();
        bready = 1'b0;
        b_count++;
        checkOutput("awready_after_b", awready, 1);
    endtask

    task automatic collectReadBurst(input logic [31:0] addr, input int len, input bit stall);
        int cnt;
        araddr  = addr;
        arlen   = 8'(len);
        arvalid = 1'b1;
        cnt = 0;
        while (!arready && cnt < 200) begin tick(); cnt++; end
        if (cnt >= 200) checkOutput("ar_timeout", 1, 0);
        tick();
        arvalid = 1'b0;
        for (int i = 0; i <= len; i++) begin
            cnt = 0;
            while (!rvalid && cnt < 200) begin tick(); cnt++; end
            if (cnt >= 200) checkOutput("r_timeout", 1, 0);
            rbuf[i]      = rdata;
            rlast_buf[i] = rlast;
            last_rid     = rid;
            if (stall) begin
                rready = 1'b0;
                tick();
                checkOutput("rdata_stable", rdata, rbuf[i]);
                checkOutput("rlast_stable", rlast, rlast_buf[i]);
                checkOutput("rvalid_held", rvalid, 1);
            end
            rready = 1'b1;
            tick();
            rready = 1'b0;
        end
        checkOutput("rvalid_done", rvalid, 0);
        checkOutput("arready_done", arready, 1);
    endtask

    task automatic checkRead(input string tag, input int idx, input logic [31:0] expected, input bit exp_last);
        checkOutput($sformatf("%s_rdata%0d", tag, idx), rbuf[idx], expected);
        checkOutput($sformatf("%s_rlast%0d", tag, idx), rlast_buf[idx], exp_last);
    endtask

    initial begin
        logic [31:0] t1 [0:8];
        logic [1:0]  exp_err;
        int          b_before;
        t1 = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd100, 32'd101, 32'd901};
`ifdef AXI_SLV_ERR_CHECK_EN
        exp_err = 2'b10;
`else
        exp_err = 2'b00;
`endif
        sys_rst = 1'b1;
        awaddr = '0; awlen = '0; awvalid = 1'b0;
        wdata = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
        araddr = '0; arlen = '0; arvalid = 1'b0; rready = 1'b0;
        repeat (3) tick();
        checkOutput("rst_awready", awready, 0);
        checkOutput("rst_wready", wready, 0);
        checkOutput("rst_bvalid", bvalid, 0);
        checkOutput("rst_bresp", bresp, 0);
        checkOutput("rst_arready", arready, 0);
        checkOutput("rst_rvalid", rvalid, 0);
        checkOutput("rst_rdata", rdata, 0);
        checkOutput("rst_rlast", rlast, 0);
        sys_rst = 1'b0;
        tick();
        tick();
        checkOutput("post_rst_awready", awready, 1);
        checkOutput("post_rst_arready", arready, 1);

        // Basic 9-beat write and read-back
        for (int i = 0; i < 9; i++) wbuf[i] = t1[i];
        applyStimulus(32'd100, 8, 0, 0, -1, -1);
        checkOutput("t1_bcount", b_count, 1);
        checkOutput("t1_bresp", last_bresp, 0);
        checkOutput("t1_bid", last_bid, 0);
        collectReadBurst(32'd100, 8, 1'b0);
        for (int i = 0; i < 9; i++) checkRead("t1", i, t1[i], i == 8);
        checkOutput("t1_rid", last_rid, 0);

        // Three back-to-back identical bursts
        b_before = b_count;
        repeat (3) applyStimulus(32'd100, 8, 0, 0, -1, -1);
        checkOutput("t2_bcount", b_count - b_before, 3);
        collectReadBurst(32'd100, 8, 1'b0);
        for (int i = 0; i < 9; i++) checkRead("t2", i, t1[i], i == 8);

        // Wrap at the top of memory
        wbuf[0] = 32'hAAAA_0001; wbuf[1] = 32'hBBBB_0002;
        wbuf[2] = 32'hCCCC_0003; wbuf[3] = 32'hDDDD_0004;
        applyStimulus(32'd254, 3, 0, 0, -1, -1);
        checkOutput("t3_bresp", last_bresp, 0);
        collectReadBurst(32'd254, 3, 1'b0);
        checkRead("t3a", 0, 32'hAAAA_0001, 0);
        checkRead("t3a", 1, 32'hBBBB_0002, 0);
        checkRead("t3a", 2, 32'hCCCC_0003, 0);
        checkRead("t3a", 3, 32'hDDDD_0004, 1);
        collectReadBurst(32'd0, 1, 1'b0);
        checkRead("t3b", 0, 32'hCCCC_0003, 0);
        checkRead("t3b", 1, 32'hDDDD_0004, 1);
        collectReadBurst(32'd255, 0, 1'b0);
        checkRead("t3c", 0, 32'hBBBB_0002, 1);
        collectReadBurst(32'd511, 0, 1'b0);
        checkRead("t3d", 0, 32'hBBBB_0002, 1);

        // wvalid gaps, delayed bready, stalled read
        for (int i = 0; i < 6; i++) wbuf[i] = 32'h1111_0000 + 32'(i);
        applyStimulus(32'd40, 5, 2, 5, -1, -1);
        checkOutput("t4_bresp", last_bresp, 0);
        collectReadBurst(32'd40, 5, 1'b1);
        checkRead("t4", 0, 32'h1111_0000, 0);
        checkRead("t4", 1, 32'h1111_0001, 0);
        checkRead("t4", 2, 32'h1111_0002, 0);
        checkRead("t4", 3, 32'h1111_0003, 0);
        checkRead("t4", 4, 32'h1111_0004, 0);
        checkRead("t4", 5, 32'h1111_0005, 1);

        // Reset pulse at beat 4 of a 9-beat write
        for (int i = 0; i < 9; i++) wbuf[i] = 32'h5000 + 32'(i);
        applyStimulus(32'd20, 8, 0, 0, -1, 4);
        sys_rst = 1'b1;
        #1;
        checkOutput("t5_awready", awready, 0);
        checkOutput("t5_wready", wready, 0);
        checkOutput("t5_bvalid", bvalid, 0);
        checkOutput("t5_arready", arready, 0);
        checkOutput("t5_rvalid", rvalid, 0);
        tick();
        sys_rst = 1'b0;
        tick();
        checkOutput("t5_awready_release", awready, 1);
        for (int i = 0; i < 3; i++) wbuf[i] = 32'h6000 + 32'(i);
        applyStimulus(32'd20, 2, 0, 0, -1, -1);
        checkOutput("t5_bresp", last_bresp, 0);
        collectReadBurst(32'd20, 3, 1'b0);
        checkRead("t5", 0, 32'h6000, 0);
        checkRead("t5", 1, 32'h6001, 0);
        checkRead("t5", 2, 32'h6002, 0);
        checkRead("t5", 3, 32'h5003, 1);

        // wlast placement: early, correct, missing
        for (int i = 0; i < 9; i++) wbuf[i] = 32'h7000 + 32'(i);
        applyStimulus(32'd60, 8, 0, 0, 3, -1);
        checkOutput("t6_early_wlast_bresp", last_bresp, exp_err);
        applyStimulus(32'd60, 8, 0, 0, -1, -1);
        checkOutput("t6_good_wlast_bresp", last_bresp, 0);
        applyStimulus(32'd60, 8, 0, 0, 99, -1);
        checkOutput("t6_missing_wlast_bresp", last_bresp, exp_err);
        collectReadBurst(32'd60, 8, 1'b0);
        for (int i = 0; i < 9; i++) checkRead("t6", i, 32'h7000 + 32'(i), i == 8);
        checkOutput("t6_rresp", rresp, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, mismatch_count);
        $finish;
    end

endmodule
